// File: rtl/vdc_blkxfer.sv
// vdc_blkxfer: CPU register front end and slot-driven RAM block mover.
// Define VDC_BLKXFER_DEC_EN to honour mode_dec (decrementing block ops).
module vdc_blkxfer #(
  parameter int ADDR_BITS = 16,
  parameter int WC_BITS   = 8,
  parameter int WCH_REG   = 38
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 reg_we,
  input  logic                 reg_re,
  input  logic [5:0]           reg_sel,
  input  logic [7:0]           reg_di,
  input  logic                 mode_copy,
  input  logic                 mode_dec,
  input  logic                 slot,
  output logic                 ram_rd,
  output logic                 ram_we,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [7:0]           ram_di,
  input  logic [7:0]           ram_do,
  output logic [ADDR_BITS-1:0] reg_ua,
  output logic [ADDR_BITS-1:0] reg_ba,
  output logic [WC_BITS-1:0]   reg_wc,
  output logic [7:0]           reg_da,
  output logic                 busy,
  output logic                 overrun
);

  localparam logic [5:0] R_UAH = 6'd18;
  localparam logic [5:0] R_UAL = 6'd19;
  localparam logic [5:0] R_WC  = 6'd30;
  localparam logic [5:0] R_DA  = 6'd31;
  localparam logic [5:0] R_BAH = 6'd32;
  localparam logic [5:0] R_BAL = 6'd33;
  localparam logic [5:0] R_WCH = 6'(WCH_REG);
  localparam bit WCH_ON = (WC_BITS > 8);

  localparam logic [ADDR_BITS-1:0] A_ONE = ADDR_BITS'(1);
  localparam logic [ADDR_BITS-1:0] A_LO  = ADDR_BITS'(8'hff);
  localparam logic [WC_BITS-1:0]   W_ONE = WC_BITS'(1);
  localparam logic [WC_BITS-1:0]   W_LO  = WC_BITS'(8'hff);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WRITE, S_FILL, S_COPY_RD, S_COPY_WR
  } state_t;

  typedef enum logic [1:0] {
    C_READ, C_WRITE, C_FILL, C_COPY
  } cmd_t;

  state_t state, state_n;
  cmd_t   q_cmd, st_cmd, pend_cmd;
  logic   q_vld, q_dec, st_go, st_dec;
  logic   pend, pend_dec, cpl, acc, last, dec;
  logic   rd, we;
  logic   w_uah, w_ual, w_wc, w_da, w_bah, w_bal, w_wch, r_da;
  logic [WC_BITS-1:0]   wc, wc_d, st_wc, pend_wc;
  logic [ADDR_BITS-1:0] ua_step, ba_step;
  logic [7:0]           wda, cda;

  assign w_uah = reg_we && reg_sel == R_UAH;
  assign w_ual = reg_we && reg_sel == R_UAL;
  assign w_wc  = reg_we && reg_sel == R_WC;
  assign w_da  = reg_we && reg_sel == R_DA;
  assign w_bah = reg_we && reg_sel == R_BAH;
  assign w_bal = reg_we && reg_sel == R_BAL;
  assign w_wch = reg_we && WCH_ON && reg_sel == R_WCH;
  assign r_da  = reg_re && !reg_we && reg_sel == R_DA;

`ifdef VDC_BLKXFER_DEC_EN
  assign q_dec = mode_dec;
`else
  assign q_dec = 1'b0;
`endif

  always_comb begin
    q_vld = 1'b1;
    q_cmd = C_READ;
    unique case (1'b1)
      w_uah, w_ual, r_da: q_cmd = C_READ;
      w_wc:    q_cmd = mode_copy ? C_COPY : C_FILL;
      w_da:    q_cmd = C_WRITE;
      default: q_vld = 1'b0;
    endcase
  end

  // word count as it will read after this cycle's CPU write
  always_comb begin
    wc_d = reg_wc;
    if (w_wc)
      wc_d = (reg_wc & ~W_LO) | WC_BITS'(reg_di);
    if (w_wch)
      wc_d = (reg_wc & W_LO) | (WC_BITS'(reg_di) << 8);
  end

  assign st_go  = (state == S_IDLE) && (q_vld || pend);
  assign st_cmd = q_vld ? q_cmd : pend_cmd;
  assign st_dec = q_vld ? q_dec : pend_dec;
  assign st_wc  = q_vld ? wc_d : pend_wc;

  assign acc  = slot && state != S_IDLE && !cpl;
  assign last = wc == W_ONE;
  assign busy = state != S_IDLE || pend;

  assign ua_step = dec ? reg_ua - A_ONE : reg_ua + A_ONE;
  assign ba_step = dec ? reg_ba - A_ONE : reg_ba + A_ONE;

  always_comb begin
    state_n  = state;
    rd       = 1'b0;
    we       = 1'b0;
    ram_addr = '1;
    ram_di   = 8'h00;
    if (st_go) begin
      unique case (st_cmd)
        C_READ:  state_n = S_READ;
        C_WRITE: state_n = S_WRITE;
        C_FILL:  state_n = S_FILL;
        C_COPY:  state_n = S_COPY_RD;
      endcase
    end else if (cpl) begin
      unique case (state)
        S_READ:    state_n = S_IDLE;
        S_WRITE:   state_n = S_READ;
        S_FILL:    state_n = last ? S_IDLE : S_FILL;
        S_COPY_RD: state_n = S_COPY_WR;
        S_COPY_WR: state_n = last ? S_IDLE : S_COPY_RD;
        default:   state_n = state;
      endcase
    end
    rd = acc && (state == S_READ || state == S_COPY_RD);
    we = acc && (state == S_WRITE || state == S_FILL ||
                 state == S_COPY_WR);
    if (rd || we)
      ram_addr = (state == S_COPY_RD) ? reg_ba : reg_ua;
    if (we)
      ram_di = (state == S_COPY_WR) ? cda : wda;
  end

  assign ram_rd = rd;
  assign ram_we = we;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cpl   <= 1'b0;
    end else begin
      state <= state_n;
      cpl   <= acc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend     <= 1'b0;
      pend_cmd <= C_READ;
      pend_dec <= 1'b0;
      pend_wc  <= '0;
      overrun  <= 1'b0;
      wc       <= '0;
      dec      <= 1'b0;
      wda      <= 8'h00;
      cda      <= 8'h00;
      reg_ua   <= '0;
      reg_ba   <= '0;
      reg_wc   <= '0;
      reg_da   <= 8'h00;
    end else begin
      if (st_go) begin
        pend <= 1'b0;
        if (q_vld && pend)
          overrun <= 1'b1;
        if (st_cmd == C_FILL || st_cmd == C_COPY) begin
          wc  <= st_wc;
          dec <= st_dec;
        end
      end else if (q_vld) begin
        pend     <= 1'b1;
        pend_cmd <= q_cmd;
        pend_dec <= q_dec;
        pend_wc  <= wc_d;
        if (pend)
          overrun <= 1'b1;
      end
      if (cpl) begin
        unique case (state)
          S_READ:    reg_da <= ram_do;
          S_COPY_RD: cda <= ram_do;
          default:   ;
        endcase
      end
      if (cpl && (state == S_FILL || state == S_COPY_WR))
        wc <= wc - W_ONE;
      if (cpl && state == S_COPY_RD)
        reg_ba <= ba_step;
      if (cpl && (state == S_WRITE || state == S_FILL ||
                  state == S_COPY_WR))
        reg_ua <= ua_step;
      // CPU accesses override the internal address step
      if (r_da)
        reg_ua <= reg_ua + A_ONE;
      if (w_uah)
        reg_ua <= (reg_ua & A_LO) | (ADDR_BITS'(reg_di) << 8);
      if (w_ual)
        reg_ua <= (reg_ua & ~A_LO) | ADDR_BITS'(reg_di);
      if (w_bah)
        reg_ba <= (reg_ba & A_LO) | (ADDR_BITS'(reg_di) << 8);
      if (w_bal)
        reg_ba <= (reg_ba & ~A_LO) | ADDR_BITS'(reg_di);
      if (w_da)
        wda <= reg_di;
      reg_wc <= wc_d;
    end
  end

endmodule

// File: tb/tb_vdc_blkxfer.sv
// tb_vdc_blkxfer: random CPU ops against a transaction-level model.
// Directed cases cover wrap, 256-word copy, overrun and mid-op reset.
module tb_vdc_blkxfer;

`ifdef VDC_BLKXFER_DEC_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        reg_we = 1'b0;
  logic        reg_re = 1'b0;
  logic [5:0]  reg_sel = 6'd0;
  logic [7:0]  reg_di = 8'h00;
  logic        mode_copy = 1'b0;
  logic        mode_dec = 1'b0;
  logic        slot = 1'b0;
  logic        ram_rd, ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_di;
  logic [7:0]  ram_do = 8'h00;
  logic [15:0] reg_ua, reg_ba;
  logic [7:0]  reg_wc, reg_da;
  logic        busy, overrun;

  vdc_blkxfer dut (
    .clk(clk), .reset_n(reset_n),
    .reg_we(reg_we), .reg_re(reg_re),
    .reg_sel(reg_sel), .reg_di(reg_di),
    .mode_copy(mode_copy), .mode_dec(mode_dec),
    .slot(slot),
    .ram_rd(ram_rd), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_di(ram_di),
    .ram_do(ram_do),
    .reg_ua(reg_ua), .reg_ba(reg_ba),
    .reg_wc(reg_wc), .reg_da(reg_da),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  logic [7:0]  dmem [0:65535];
  logic [7:0]  rmem [0:65535];
  logic [24:0] obs[$];
  logic [24:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          slot_per = 0;
  int          cyc = 0;
  int          we_cnt = 0;
  logic        both_hi = 1'b0;

  logic [15:0] m_ua, m_ba;
  logic [7:0]  m_da, m_wda, m_wc;
  logic        m_dec;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // bench RAM plus access monitor
  always @(negedge clk) begin
    if (ram_rd && ram_we) both_hi = 1'b1;
    if (ram_we) begin
      we_cnt++;
      obs.push_back({1'b1, ram_addr, ram_di});
      dmem[ram_addr] = ram_di;
    end
    if (ram_rd) begin
      obs.push_back({1'b0, ram_addr, 8'h00});
      ram_do = dmem[ram_addr];
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (slot_per != 0) slot = (cyc % slot_per) == 0;
      else slot = ($urandom_range(0, 2) == 0);
    end
  end

  function automatic logic [15:0] mstep(input logic [15:0] a);
    return m_dec ? a - 16'd1 : a + 16'd1;
  endfunction

  task automatic m_read();
    exp_q.push_back({1'b0, m_ua, 8'h00});
    m_da = rmem[m_ua];
  endtask

  task automatic m_write(input logic [7:0] d);
    exp_q.push_back({1'b1, m_ua, d});
    rmem[m_ua] = d;
  endtask

  task automatic cpu_wr(input logic [5:0] sel, input logic [7:0] d,
                        input logic cp, input logic dc);
    reg_sel = sel; reg_di = d; mode_copy = cp; mode_dec = dc;
    reg_we = 1'b1;
    @(posedge clk);
    #1;
    reg_we = 1'b0;
    mode_copy = 1'($urandom);
    mode_dec = 1'($urandom);
  endtask

  task automatic cpu_rd();
    reg_sel = 6'd31;
    reg_re = 1'b1;
    @(posedge clk);
    #1;
    reg_re = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", busy, 1'b0);
    @(posedge clk);
    #1;
  endtask

  // kinds: 0 UAH, 1 UAL, 2 DA write, 3 DA read, 4 FILL, 5 COPY, 6 BAH, 7 BAL
  task automatic op(input int kind, input logic [7:0] d, input logic dc);
    int n;
    logic [7:0] b;
    obs.delete();
    exp_q.delete();
    n = (d == 8'h00) ? 256 : int'(d);
    case (kind)
      0: begin m_ua[15:8] = d; m_read(); cpu_wr(6'd18, d, 0, 0); end
      1: begin m_ua[7:0] = d; m_read(); cpu_wr(6'd19, d, 0, 0); end
      2: begin
        m_wda = d; m_write(d); m_ua = mstep(m_ua); m_read();
        cpu_wr(6'd31, d, 0, 0);
      end
      3: begin m_ua = m_ua + 16'd1; m_read(); cpu_rd(); end
      4: begin
        m_wc = d; m_dec = DEC_EN & dc;
        for (int i = 0; i < n; i++) begin
          m_write(m_wda); m_ua = mstep(m_ua);
        end
        cpu_wr(6'd30, d, 1'b0, dc);
      end
      5: begin
        m_wc = d; m_dec = DEC_EN & dc;
        for (int i = 0; i < n; i++) begin
          exp_q.push_back({1'b0, m_ba, 8'h00});
          b = rmem[m_ba]; m_ba = mstep(m_ba);
          m_write(b); m_ua = mstep(m_ua);
        end
        cpu_wr(6'd30, d, 1'b1, dc);
      end
      6: begin m_ba[15:8] = d; cpu_wr(6'd32, d, 0, 0); end
      default: begin m_ba[7:0] = d; cpu_wr(6'd33, d, 0, 0); end
    endcase
    wait_idle(20000);
    chk("n_acc", obs.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++)
      chk($sformatf("acc%0d", i), obs[i], exp_q[i]);
    chk("ua", reg_ua, m_ua);
    chk("ba", reg_ba, m_ba);
    chk("da", reg_da, m_da);
    chk("wc", reg_wc, m_wc);
    chk("ovr", overrun, 1'b0);
  endtask

  initial begin
    int nrd, nwe, k;
    logic [7:0] v;
    for (int i = 0; i < 65536; i++) begin
      v = 8'($urandom);
      dmem[i] = v;
      rmem[i] = v;
    end
    m_ua = 0; m_ba = 0; m_da = 0; m_wda = 0; m_wc = 0; m_dec = 0;
    #1;
    chk("rst_rd", ram_rd, 1'b0);
    chk("rst_we", ram_we, 1'b0);
    chk("rst_addr", ram_addr, 16'hffff);
    chk("rst_ua", reg_ua, 16'h0000);
    chk("rst_ba", reg_ba, 16'h0000);
    chk("rst_wc", reg_wc, 8'h00);
    chk("rst_da", reg_da, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovr", overrun, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    slot_per = 8;
    op(0, 8'h10, 0);
    op(1, 8'h00, 0);
    op(2, 8'h5a, 0);
    chk("d_write_ua", reg_ua, 16'h1001);
    slot_per = 0;

    op(2, 8'h33, 0);
    op(0, 8'hff, 0);
    op(1, 8'hfe, 0);
    op(4, 8'h03, 0);
    chk("fill_wrap_ua", reg_ua, 16'h0001);
    chk("fill_wc_kept", reg_wc, 8'h03);

    op(6, 8'h20, 0);
    op(7, 8'h00, 0);
    op(0, 8'h30, 0);
    op(1, 8'h00, 0);
    op(5, 8'h00, 0);
    chk("copy_ba", reg_ba, 16'h2100);
    chk("copy_ua", reg_ua, 16'h3100);

    op(0, 8'h00, 0);
    op(1, 8'h01, 0);
    op(4, 8'h02, 1);
    chk("dec_ua", reg_ua, DEC_EN ? 16'hffff : 16'h0003);

    for (int t = 0; t < 40; t++) begin
      k = $urandom_range(0, 7);
      if (k == 4 || k == 5) v = 8'($urandom_range(0, 6));
      else v = 8'($urandom);
      op(k, v, 1'($urandom));
    end

    obs.delete();
    cpu_wr(6'd30, 8'h04, 1'b0, 1'b0);
    cpu_wr(6'd18, 8'h40, 1'b0, 1'b0);
    cpu_wr(6'd19, 8'h00, 1'b0, 1'b0);
    chk("ovr_busy", busy, 1'b1);
    wait_idle(20000);
    chk("ovr_set", overrun, 1'b1);
    nrd = 0; nwe = 0;
    foreach (obs[i]) if (obs[i][24]) nwe++; else nrd++;
    chk("ovr_nwe", nwe, 4);
    chk("ovr_nrd", nrd, 1);
    if (obs.size() > 0)
      chk("ovr_last_rd", obs[obs.size()-1][24], 1'b0);

    obs.delete();
    cpu_wr(6'd30, 8'h04, 1'b1, 1'b0);
    k = 0;
    @(negedge clk);
    while (!ram_rd && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("mid_rd_seen", ram_rd, 1'b1);
    @(posedge clk);
    #1;
    nwe = we_cnt;
    reset_n = 1'b0;
    #1;
    chk("mid_we", ram_we, 1'b0);
    chk("mid_addr", ram_addr, 16'hffff);
    chk("mid_ua", reg_ua, 16'h0000);
    chk("mid_ba", reg_ba, 16'h0000);
    chk("mid_wc", reg_wc, 8'h00);
    chk("mid_da", reg_da, 8'h00);
    chk("mid_busy", busy, 1'b0);
    chk("mid_ovr", overrun, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_no_we", we_cnt, nwe);
    chk("mid_idle", busy, 1'b0);
    chk("never_both", both_hi, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vdc_blkxfer.md
VDC_BLKXFER -- requirements
Module: vdc_blkxfer

Interface
REQ-001 Parameter ADDR_BITS, default 16: width of UA, BA and RAM address; all address arithmetic is modulo 2^ADDR_BITS.
REQ-002 Parameter WC_BITS, default 8, range 8..16: word-count width.
REQ-003 Parameter WCH_REG, default 38: register number that loads WC[WC_BITS-1:8]; ignored when WC_BITS=8.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 reg_we  in  1  CPU register write strobe, one cycle.
REQ-007 reg_re  in  1  CPU data-register read strobe, one cycle.
REQ-008 reg_sel  in  6  selected register number.
REQ-009 reg_di  in  8  CPU write data.
REQ-010 mode_copy  in  1  a WC write starts COPY when 1, FILL when 0.
REQ-011 mode_dec  in  1  a WC write starts a decrementing block op when 1.
REQ-012 slot  in  1  one-cycle pulse: the RAM slot is granted to this block.
REQ-013 ram_rd, ram_we  out  1 each  RAM strobes, one cycle wide, never both high.
REQ-014 ram_addr  out  ADDR_BITS  RAM address.
REQ-015 ram_di  out  8  RAM write data.
REQ-016 ram_do  in  8  RAM read data, valid the cycle after ram_rd.
REQ-017 reg_ua, reg_ba  out  ADDR_BITS each  update and block-source addresses.
REQ-018 reg_wc  out  WC_BITS  last written word count; reg_da  out  8  data register.
REQ-019 busy  out  1  high whenever state is not IDLE or a command is pending.
REQ-020 overrun  out  1  sticky; set when a pending command is replaced.

Function
REQ-021 Register map: 18 UA high byte, 19 UA low byte, 30 WC low byte plus start, 31 DA, 32 BA high, 33 BA low, WCH_REG WC high bits; UA/BA high writes load bits [ADDR_BITS-1:8].
REQ-022 Writes to 18 or 19 queue READ; writes to 30 queue FILL or COPY; writes to 31 latch wda and queue WRITE; reg_re with reg_sel=31 increments UA and queues READ.
REQ-023 Writes to 32, 33 and WCH_REG update registers only and queue nothing.
REQ-024 States: IDLE, READ, WRITE, FILL, COPY_RD, COPY_WR; each non-IDLE state consumes exactly one slot per RAM access.
REQ-025 Queuing a command in IDLE enters the command's state on the next cycle.
REQ-026 Queuing while not IDLE places the command in a one-deep pending slot; the new command replaces any existing pending command and sets overrun.
REQ-027 On slot in a non-IDLE state, drive the RAM op for that cycle: READ rd@UA; WRITE/FILL we@UA with wda; COPY_RD rd@BA; COPY_WR we@UA with cda.
REQ-028 Completion occurs on the cycle after the slot: READ loads DA from ram_do, then IDLE; WRITE steps UA, then READ.
REQ-029 FILL completion steps UA and decrements wc; COPY_RD latches cda and steps BA, then COPY_WR; COPY_WR steps UA, decrements wc, then COPY_RD.
REQ-030 FILL and COPY_WR go to IDLE when wc was 1 before the decrement.
REQ-031 "Step" is +1, or -1 when the latched direction is decrementing; UA and BA wrap modulo 2^ADDR_BITS in both directions.
REQ-032 WC=0 at start transfers 2^WC_BITS words.
REQ-033 Block ops do not modify reg_wc or reg_da.
REQ-034 On entering IDLE with a command pending, the pending command starts on the next cycle and is cleared.
REQ-035 Slot pulses arriving in IDLE, or in a completion cycle, are ignored.
REQ-036 Outside RAM ops, ram_addr holds all-ones and ram_rd, ram_we are low.
REQ-037 A CPU write to UA/BA in the same cycle as an internal step gives the CPU write priority.
REQ-038 Direction (mode_dec) and op type (mode_copy) are latched at the WC write; later changes are ignored until the next WC write.

Reset
REQ-039 reset_n low immediately forces IDLE, clears pending, overrun, wc, wda, cda, reg_ua, reg_ba, reg_wc, reg_da and busy to 0, and sets ram_addr to all-ones.
REQ-040 Reset mid-operation aborts without further RAM strobes; no state survives.

Configuration
REQ-041 Macro VDC_BLKXFER_DEC_EN: when defined, mode_dec is honoured per REQ-031 and REQ-038.
REQ-042 When VDC_BLKXFER_DEC_EN is undefined, mode_dec is ignored and every step is +1.

Verification
REQ-043 UA=0x1000, DA write 0x5A, slots every 8 cycles -> we@0x1000 with 0x5A; UA becomes 0x1001; READ@0x1001 loads DA; busy drops.
REQ-044 UA=0xFFFE, wda=0x33, FILL WC=3 -> writes at 0xFFFE, 0xFFFF, 0x0000; UA ends at 0x0001; reg_wc stays 3.
REQ-045 BA=0x2000, UA=0x3000, COPY WC=0 (WC_BITS=8) -> 256 rd/we pairs; BA ends at 0x2100 and UA at 0x3100.
REQ-046 With DEC_EN, UA=0x0001, FILL WC=2, mode_dec=1 -> writes at 0x0001, 0x0000; UA ends at 0xFFFF; without DEC_EN -> 0x0001, 0x0002.
REQ-047 During FILL, write UA twice -> overrun=1; only the second READ executes after FILL completes.
REQ-048 Assert reset_n low between COPY_RD and COPY_WR -> no ram_we; all outputs are at reset values asynchronously.
